// File: rtl/skid_buffer.sv
// skid_buffer: two-entry elastic valid/ready stage. Both the forward path
// (out_valid/out_data) and the backward path (in_ready) come straight from
// flops, so no combinational path crosses the stage in either direction.
// Sustains one word per cycle when the consumer is always ready.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // EMPTY: nothing held; BUSY: main register holds the head word;
  // FULL: main holds the head, skid holds the word caught while stalled.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_main;

  // Next state and register-load selects from the two handshakes.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_load_main = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_main = 1'b1;
        end else if (w_in_xfer) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_xfer) begin
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_nxt      = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State and handshake flags; ready/valid are decoded from the next state
  // so they are registered yet track the state with no extra cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // Data registers; main is left untouched when draining to EMPTY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : in_data;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: directed and randomized checks of skid_buffer against a
// two-slot FIFO reference model held as a queue.
module tb_skid_buffer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  skid_buffer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words in flight, capacity two, plus expected ready.
  logic [WIDTH-1:0] q[$];
  logic             m_rdy;
  logic             last_acc;
  int               n_tests;
  int               n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    check({tag, ".in_ready"},  32'(in_ready),  32'(m_rdy));
    if (q.size() > 0)
      check({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
  endtask

  // One clock: evaluate handshakes from the model, advance, then compare.
  task automatic step(input string tag);
    logic             in_x;
    logic             out_x;
    logic             stall;
    logic [WIDTH-1:0] held;
    in_x  = in_valid && m_rdy;
    out_x = (q.size() > 0) && out_ready;
    stall = (q.size() > 0) && !out_ready;
    held  = (q.size() > 0) ? q[0] : '0;
    @(posedge clk);
    if (out_x) void'(q.pop_front());
    if (in_x)  q.push_back(in_data);
    m_rdy    = (q.size() < 2);
    last_acc = in_x;
    #1;
    check_model(tag);
    if (stall) begin
      check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".stall_data"},  32'(out_data),  32'(held));
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    q         = {};
    m_rdy     = 1'b0;
    last_acc  = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset values while rst is held.
    #2;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check("rst.out_data",  32'(out_data),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rel.in_ready_low", 32'(in_ready), 32'd0);
    step("rel");
    check("rel.in_ready_high", 32'(in_ready), 32'd1);

    // Fill to FULL, then an asynchronous reset pulse between edges.
    in_valid = 1'b1; in_data = 8'h11; step("fill1");
    in_data  = 8'h22;                 step("fill2");
    check("fill.in_ready", 32'(in_ready), 32'd0);
    check("fill.out_data", 32'(out_data), 32'h11);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready",  32'(in_ready),  32'd0);
    check("midrst.out_data",  32'(out_data),  32'd0);
    #2 rst = 1'b0;
    q = {};
    m_rdy = 1'b0;
    out_ready = 1'b1;
    step("postrst1");
    check("postrst.in_ready", 32'(in_ready), 32'd1);
    step("postrst2");
    check("postrst.no_stale", 32'(out_valid), 32'd0);

    // Single word.
    in_valid = 1'b1; in_data = 8'h5A; step("single1");
    check("single.valid", 32'(out_valid), 32'd1);
    check("single.data",  32'(out_data),  32'h5A);
    in_valid = 1'b0; step("single2");
    check("single.gone", 32'(out_valid), 32'd0);

    // Streaming 0..99 with the consumer always ready.
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(i);
      step("stream");
      check("stream.in_ready", 32'(in_ready), 32'd1);
      check("stream.data",     32'(out_data), 32'(i));
    end
    in_valid = 1'b0; step("stream_end");

    // Backpressure.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11; step("bp1");
    in_data = 8'h22; step("bp2");
    check("bp.in_ready0", 32'(in_ready), 32'd0);
    check("bp.head11",    32'(out_data), 32'h11);
    in_data = 8'h33; step("bp3");
    step("bp4");
    check("bp.hold11", 32'(out_data), 32'h11);
    out_ready = 1'b1; step("bp5");
    check("bp.out22",    32'(out_data), 32'h22);
    check("bp.33_wait",  32'(last_acc), 32'd0);
    step("bp6");
    check("bp.33_taken", 32'(last_acc), 32'd1);
    check("bp.out33",    32'(out_data), 32'h33);
    in_valid = 1'b0; step("bp7");
    check("bp.drained", 32'(out_valid), 32'd0);

    // Simultaneous in/out with alternating consumer ready.
    in_valid = 1'b1;
    in_data  = 8'h80;
    for (int i = 0; i < 24; i++) begin
      out_ready = i[0];
      step("alt");
      if (last_acc) in_data = in_data + 8'd1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step("alt_d1"); step("alt_d2");

    // Random soak.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = WIDTH'($urandom);
      step("soak");
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step("drain1"); step("drain2"); step("drain3");
    check("drain.empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
